// File: rtl/estimate_combiner.sv
// Final stage of the control-bounded filter: sums N channel estimates, rounds,
// saturates and decimates them, and presents each result on a valid/ready register.
module estimate_combiner #(
    parameter int N     = 3,
    parameter int IN_W  = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8,
    parameter int DECIM = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N*IN_W-1:0]       in_re,
    input  logic                    in_valid,
    output logic signed [OUT_W-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_flag,
    output logic                    drop_flag,
    input  logic                    flag_clr
);

    localparam int SW = IN_W + $clog2(N) + 1;
    localparam int RW = SW + 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [RW-1:0] HALF = RW'((2 ** SHIFT) / 2);
    localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [SW-1:0]    sum_next;
    logic signed [SW-1:0]    sum_a;
    logic                    va;

    logic signed [RW-1:0]    sum_ext;
    logic signed [RW-1:0]    rounded;
    logic signed [OUT_W-1:0] sat_val;
    logic                    clip;

    logic [CW-1:0]           cnt;
    logic signed [OUT_W-1:0] res_b;
    logic                    clip_b;
    logic                    cand_b;

    always_comb begin
        sum_next = '0;
        for (int k = 0; k < N; k++) begin
            sum_next = sum_next + SW'($signed(in_re[k*IN_W +: IN_W]));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_a <= '0;
            va    <= 1'b0;
        end else begin
            va <= in_valid;
            if (in_valid) begin
                sum_a <= sum_next;
            end
        end
    end

    // The extra bit above the sum width absorbs the rounding offset without wrapping.
    always_comb begin
        sum_ext = RW'(sum_a);
        rounded = (sum_ext + HALF) >>> SHIFT;
        sat_val = rounded[OUT_W-1:0];
        clip    = 1'b0;
        if (rounded > MAXV) begin
            sat_val = MAXV[OUT_W-1:0];
            clip    = 1'b1;
        end else if (rounded < MINV) begin
            sat_val = MINV[OUT_W-1:0];
            clip    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            res_b  <= '0;
            clip_b <= 1'b0;
            cand_b <= 1'b0;
        end else begin
            cand_b <= va && (cnt == '0);
            if (va) begin
                res_b  <= sat_val;
                clip_b <= clip;
                cnt    <= (cnt == CW'(DECIM - 1)) ? '0 : cnt + 1'b1;
            end
        end
    end

    // The core cannot stall, so a candidate arriving at a full, unread register is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (cand_b && (!out_valid || out_ready)) begin
                out       <= res_b;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            if (cand_b && clip_b) begin
                sat_flag <= 1'b1;
            end else if (flag_clr) begin
                sat_flag <= 1'b0;
            end
            if (cand_b && out_valid && !out_ready) begin
                drop_flag <= 1'b1;
            end else if (flag_clr) begin
                drop_flag <= 1'b0;
            end
        end
    end

endmodule
